// File: rtl/seq_shift_register_if.sv
// Command/result bundle for seq_shift_register.
// The master side issues commands; the slave side returns the register state.
// op_ready is the slave's acceptance qualifier for op_valid.
interface seq_shift_register_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int SHAMT_WIDTH = 4
);
  logic                   op_valid;
  logic                   op_ready;
  logic [2:0]             op;
  logic [DATA_WIDTH-1:0]  in;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   fill;
  logic [DATA_WIDTH-1:0]  out;
  logic                   carry;
  logic                   zero;
  logic                   busy;
  logic                   done;

  modport master (
    output op_valid, op, in, shamt, fill,
    input  op_ready, out, carry, zero, busy, done
  );

  modport slave (
    input  op_valid, op, in, shamt, fill,
    output op_ready, out, carry, zero, busy, done
  );
endinterface

// File: rtl/seq_shift_register.sv
// Accumulator/shifter: CLR/LD/INC/DEC plus serial SHR/SHL/ROR with carry and zero flags.
// Latency: single-cycle ops and shamt<=1 finish at the accept edge; shifts take shamt edges.
// Backpressure: op_ready low while a multi-step shift runs; commands offered then are dropped.
module seq_shift_register #(
  parameter int DATA_WIDTH  = 16,
  parameter int SHAMT_WIDTH = 4,
  parameter bit SATURATE    = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  seq_shift_register_if.slave bus
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_CLR = 3'd1;
  localparam logic [2:0] OP_LD  = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_DEC = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_ROR = 3'd7;

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE  = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]  DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  state_e                 state_q, state_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]             sop_q, sop_d;
  logic                   fill_q, fill_d;
  logic [DATA_WIDTH-1:0]  out_q, out_d;
  logic                   carry_q, carry_d;
  logic                   done_q, done_d;

  logic [2:0]             step_op;
  logic                   step_fill;
  logic [DATA_WIDTH:0]    step_res;
  logic [DATA_WIDTH:0]    inc_sum;

  // One 1-bit shift step {carry, out}; the first step uses the live command, later ones the latched copy.
  always_comb begin
    step_op   = (state_q == ST_SHIFT) ? sop_q  : bus.op;
    step_fill = (state_q == ST_SHIFT) ? fill_q : bus.fill;
    step_res  = {carry_q, out_q};
    case (step_op)
      OP_SHR:  step_res = {out_q[0], step_fill, out_q[DATA_WIDTH-1:1]};
      OP_SHL:  step_res = {out_q[DATA_WIDTH-1], out_q[DATA_WIDTH-2:0], step_fill};
      OP_ROR:  step_res = {out_q[0], out_q[0], out_q[DATA_WIDTH-1:1]};
      default: step_res = {carry_q, out_q};
    endcase
  end

  assign inc_sum = {1'b0, out_q} + {1'b0, DATA_ONE};

  // Next-state logic: command decode in IDLE, serial stepping in SHIFT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    fill_d  = fill_q;
    out_d   = out_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          done_d = 1'b1;
          case (bus.op)
            OP_NOP: ;
            OP_CLR: begin
              out_d   = '0;
              carry_d = 1'b0;
            end
            OP_LD: begin
              out_d   = bus.in;
              carry_d = 1'b0;
            end
            OP_INC: begin
              if (SATURATE && (&out_q)) begin
                carry_d = 1'b1;
              end else begin
                {carry_d, out_d} = inc_sum;
              end
            end
            OP_DEC: begin
              carry_d = (out_q == '0);
              if (!(SATURATE && (out_q == '0))) begin
                out_d = out_q - DATA_ONE;
              end
            end
            default: begin
              // Shift/rotate: zero amount is a no-op; otherwise the accept edge is step one.
              if (bus.shamt != '0) begin
                {carry_d, out_d} = step_res;
                sop_d  = bus.op;
                fill_d = bus.fill;
                if (bus.shamt != CNT_ONE) begin
                  state_d = ST_SHIFT;
                  cnt_d   = bus.shamt - CNT_ONE;
                  done_d  = 1'b0;
                end
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        {carry_d, out_d} = step_res;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any shift in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sop_q   <= OP_NOP;
      fill_q  <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign bus.op_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q == ST_SHIFT);
  assign bus.out      = out_q;
  assign bus.carry    = carry_q;
  assign bus.zero     = (out_q == '0);
  assign bus.done     = done_q;

endmodule
